// File: rtl/free_list_ckpt.sv
// rtl/free_list_ckpt.sv - physical-register free list with branch checkpoints
// Circular list of free phregs; head checkpoints restore on mispredict, commit head restores on flush.
module free_list_ckpt #(
  parameter int NUM_PHYS = 64,
  parameter int NUM_ARCH = 32,
  parameter int NUM_CKPT = 4,
  parameter int PH_W     = $clog2(NUM_PHYS)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        alloc_i,
  output logic [PH_W-1:0]             free_reg_o,
  output logic                        empty_o,
  input  logic                        commit_alloc_i,
  input  logic                        release_i,
  input  logic [PH_W-1:0]             release_reg_i,
  input  logic                        do_ckpt_i,
  output logic [$clog2(NUM_CKPT)-1:0] ckpt_id_o,
  output logic                        out_of_ckpt_o,
  input  logic                        delete_ckpt_i,
  input  logic                        recover_i,
  input  logic [$clog2(NUM_CKPT)-1:0] recover_id_i,
  input  logic                        flush_i
);

  localparam int D     = NUM_PHYS - NUM_ARCH;
  localparam int IDX_W = $clog2(D);
  localparam int PTR_W = IDX_W + 1;
  localparam int CK_W  = $clog2(NUM_CKPT);
  localparam int CP_W  = CK_W + 1;

  logic [PH_W-1:0]  ids  [D];
  logic [PTR_W-1:0] snap [NUM_CKPT];
  logic [PTR_W-1:0] head, tail, commit_head, count;
  logic [PTR_W-1:0] head_next, commit_head_next;
  logic [CP_W-1:0]  ckpt_head, ckpt_tail, ckpt_live, rec_tail;
  logic [CK_W-1:0]  rec_off;
  logic             alloc_ok, rel_ok, ckpt_ok, del_ok;

  assign count         = tail - head;
  assign empty_o       = (count == '0);
  assign free_reg_o    = ids[head[IDX_W-1:0]];
  assign ckpt_live     = ckpt_tail - ckpt_head;
  assign out_of_ckpt_o = (ckpt_live == CP_W'(NUM_CKPT));
  assign ckpt_id_o     = ckpt_tail[CK_W-1:0];

  assign alloc_ok         = alloc_i & ~empty_o;
  assign rel_ok           = release_i & (release_reg_i != '0);
  assign ckpt_ok          = do_ckpt_i & ~out_of_ckpt_o;
  assign del_ok           = delete_ckpt_i & (ckpt_live != '0);
  assign head_next        = head + PTR_W'(alloc_ok);
  assign commit_head_next = commit_head + PTR_W'(commit_alloc_i);

  // Rebuild the wrapped checkpoint tail so that its index equals recover_id_i
  // while staying inside the live window starting at ckpt_head.
  assign rec_off  = recover_id_i - ckpt_head[CK_W-1:0];
  assign rec_tail = ckpt_head + {1'b0, rec_off};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < D; i++) ids[i] <= PH_W'(NUM_ARCH + i);
      for (int i = 0; i < NUM_CKPT; i++) snap[i] <= '0;
      head        <= '0;
      tail        <= PTR_W'(D);
      commit_head <= '0;
      ckpt_head   <= '0;
      ckpt_tail   <= '0;
    end else begin
      if (rel_ok) begin
        ids[tail[IDX_W-1:0]] <= release_reg_i;
        tail                 <= tail + PTR_W'(1);
      end
      commit_head <= commit_head_next;
      if (flush_i) begin
        head      <= commit_head_next;
        ckpt_head <= '0;
        ckpt_tail <= '0;
      end else if (recover_i) begin
        head      <= snap[recover_id_i];
        ckpt_tail <= rec_tail;
      end else begin
        head <= head_next;
        if (ckpt_ok) begin
          snap[ckpt_tail[CK_W-1:0]] <= head_next;
          ckpt_tail                 <= ckpt_tail + CP_W'(1);
        end
        if (del_ok) ckpt_head <= ckpt_head + CP_W'(1);
      end
    end
  end

  a_release_not_full: assert property (@(posedge clk_i) disable iff (rst_i)
    rel_ok |-> (count != PTR_W'(D)));

  a_commit_behind_head: assert property (@(posedge clk_i) disable iff (rst_i)
    commit_alloc_i |-> (commit_head != head));

endmodule

// File: tb/tb_free_list_ckpt.sv
// tb/tb_free_list_ckpt.sv - randomized and directed bench for free_list_ckpt
// Reference model uses unbounded integer pointers and a queue of live checkpoints.
module tb_free_list_ckpt;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       alloc_i, commit_alloc_i, release_i, do_ckpt_i, delete_ckpt_i;
  logic       recover_i, flush_i;
  logic [5:0] release_reg_i, free_reg_o;
  logic [1:0] recover_id_i, ckpt_id_o;
  logic       empty_o, out_of_ckpt_o;

  free_list_ckpt dut (
    .clk_i(clk_i), .rst_i(rst_i), .alloc_i(alloc_i), .free_reg_o(free_reg_o),
    .empty_o(empty_o), .commit_alloc_i(commit_alloc_i), .release_i(release_i),
    .release_reg_i(release_reg_i), .do_ckpt_i(do_ckpt_i), .ckpt_id_o(ckpt_id_o),
    .out_of_ckpt_o(out_of_ckpt_o), .delete_ckpt_i(delete_ckpt_i),
    .recover_i(recover_i), .recover_id_i(recover_id_i), .flush_i(flush_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int id; int head; } ck_t;

  int         n_checks = 0;
  int         n_errors = 0;
  int         m_head, m_tail, m_chead, m_nid;
  logic [5:0] m_arr [32];
  ck_t        q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    alloc_i = 0; commit_alloc_i = 0; release_i = 0; release_reg_i = 0;
    do_ckpt_i = 0; delete_ckpt_i = 0; recover_i = 0; recover_id_i = 0; flush_i = 0;
  endtask

  task automatic model_reset();
    m_head = 0; m_tail = 32; m_chead = 0; m_nid = 0;
    q.delete();
    for (int i = 0; i < 32; i++) m_arr[i] = 6'(32 + i);
  endtask

  task automatic check_outputs();
    logic exp_empty;
    exp_empty = (m_tail == m_head);
    check("empty", empty_o, exp_empty);
    if (!exp_empty) check("free_reg", free_reg_o, m_arr[m_head % 32]);
    check("ckpt_id", ckpt_id_o, m_nid);
    check("out_of_ckpt", out_of_ckpt_o, q.size() == 4);
  endtask

  // Apply the currently driven inputs for one clock, update the model, check at negedge.
  task automatic cycle();
    bit was_empty;
    int old_sz, hn, idx;
    was_empty = (m_tail == m_head);
    old_sz = q.size();
    if (release_i && release_reg_i != 0) begin
      m_arr[m_tail % 32] = release_reg_i;
      m_tail++;
    end
    if (commit_alloc_i) m_chead++;
    if (flush_i) begin
      m_head = m_chead;
      q.delete();
      m_nid = 0;
    end else if (recover_i) begin
      idx = 0;
      for (int k = 0; k < q.size(); k++) if (q[k].id == int'(recover_id_i)) idx = k;
      m_head = q[idx].head;
      while (q.size() > idx) void'(q.pop_back());
      m_nid = recover_id_i;
    end else begin
      hn = m_head + ((alloc_i && !was_empty) ? 1 : 0);
      if (do_ckpt_i && old_sz < 4) begin
        q.push_back('{m_nid, hn});
        m_nid = (m_nid + 1) % 4;
      end
      if (delete_ckpt_i && old_sz > 0) void'(q.pop_front());
      m_head = hn;
    end
    @(negedge clk_i);
    clear_inputs();
    check_outputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1;
    model_reset();
    #1;
    check("rst_empty", empty_o, 0);
    check("rst_free", free_reg_o, 32);
    check("rst_ckpt_id", ckpt_id_o, 0);
    check("rst_ooc", out_of_ckpt_o, 0);
    @(negedge clk_i);
    rst_i = 0;
  endtask

  function automatic bit commit_ok();
    if (m_head - m_chead < 1) return 0;
    foreach (q[k]) if (q[k].head - m_chead < 1) return 0;
    return 1;
  endfunction

  initial begin
    clear_inputs();
    rst_i = 1;
    @(negedge clk_i);
    do_reset();

    // Drain all 32 free registers, then one extra alloc.
    for (int i = 0; i < 32; i++) begin
      check("t1_free", free_reg_o, 32 + i);
      alloc_i = 1; cycle();
    end
    check("t1_empty", empty_o, 1);
    alloc_i = 1; cycle();
    check("t1_head", dut.head, 32);

    // Release into an empty list becomes visible one cycle later.
    check("t2_empty_same", empty_o, 1);
    release_i = 1; release_reg_i = 40; cycle();
    check("t2_free", free_reg_o, 40);
    check("t2_empty_next", empty_o, 0);

    do_reset();
    alloc_i = 1; cycle();
    alloc_i = 1; cycle();
    check("t3_id", ckpt_id_o, 0);
    do_ckpt_i = 1; cycle();
    alloc_i = 1; cycle();
    alloc_i = 1; cycle();
    recover_i = 1; recover_id_i = 0; cycle();
    check("t3_free", free_reg_o, 34);
    check("t3_count", dut.count, 30);
    check("t3_ooc", out_of_ckpt_o, 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("t4_id", ckpt_id_o, i);
      do_ckpt_i = 1; cycle();
    end
    check("t4_ooc_full", out_of_ckpt_o, 1);
    do_ckpt_i = 1; cycle();
    check("t4_ooc_still", out_of_ckpt_o, 1);
    delete_ckpt_i = 1; cycle();
    check("t4_ooc_del", out_of_ckpt_o, 0);
    check("t4_id_wrap", ckpt_id_o, 0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc_i = 1; do_ckpt_i = (i == 2); cycle();
    end
    commit_alloc_i = 1; cycle();
    commit_alloc_i = 1; cycle();
    flush_i = 1; cycle();
    check("t5_free", free_reg_o, 34);
    check("t5_count", dut.count, 30);
    check("t5_ckpt_id", ckpt_id_o, 0);
    check("t5_ooc", out_of_ckpt_o, 0);

    do_reset();
    alloc_i = 1; cycle();
    alloc_i = 1; cycle();
    do_ckpt_i = 1; cycle();
    alloc_i = 1; cycle();
    alloc_i = 1; cycle();
    recover_i = 1; recover_id_i = 0; alloc_i = 1; release_i = 1; release_reg_i = 50; cycle();
    check("t6_free", free_reg_o, 34);
    check("t6_slot", dut.ids[0], 50);
    check("t6_tail", dut.tail, 33);
    release_i = 1; release_reg_i = 0; cycle();
    check("t6_tail_r0", dut.tail, 33);
    check("t6_count", dut.count, 31);

    // Randomized traffic with occasional asynchronous reset.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        alloc_i = ($urandom_range(0, 9) < 6);
        if (m_tail - m_chead < 32 && $urandom_range(0, 1) == 1) begin
          release_i = 1;
          release_reg_i = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        end
        commit_alloc_i = commit_ok() && ($urandom_range(0, 9) < 4);
        do_ckpt_i      = ($urandom_range(0, 4) == 0);
        delete_ckpt_i  = ($urandom_range(0, 9) == 0);
        if (q.size() > 0 && $urandom_range(0, 24) == 0) begin
          recover_i    = 1;
          recover_id_i = 2'(q[$urandom_range(0, q.size() - 1)].id);
        end
        flush_i = ($urandom_range(0, 49) == 0);
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
